// File: rtl/msg_ram_writer.sv
// Packs a 32-bit little-endian message stream into D_WIDTH-bit blocks and writes
// them into a ring of 2**A_WIDTH RAM slots, tracking occupancy and the final block.
module msg_ram_writer #(
  parameter int unsigned D_WIDTH = 128,
  parameter int unsigned A_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  input  logic [2:0]         in_bytes,
  output logic               w_en,
  output logic [A_WIDTH-1:0] w_addr,
  output logic [D_WIDTH-1:0] w_data,
  input  logic               blk_done,
  output logic [A_WIDTH:0]   blk_cnt,
  output logic               last_vld,
  output logic [A_WIDTH-1:0] last_addr,
  output logic [4:0]         last_len
);

  localparam int unsigned CW    = A_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << A_WIDTH;

  typedef enum logic {
    COLLECT = 1'b0,
    WRITE   = 1'b1
  } state_t;

  state_t             state_q;
  logic [1:0]         lane_q;
  logic [D_WIDTH-1:0] asm_q;
  logic [A_WIDTH-1:0] wr_ptr_q;
  logic [A_WIDTH-1:0] rd_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic               w_en_q;
  logic               pend_last_q;
  logic [4:0]         pend_len_q;
  logic               last_vld_q;
  logic [A_WIDTH-1:0] last_addr_q;
  logic [4:0]         last_len_q;

  logic [2:0]  bytes_eff;
  logic [31:0] word_masked;
  logic        full;
  logic        accept;
  logic        blk_end;
  logic        wr_fire;
  logic        done_eff;
  logic [4:0]  len_d;

  // Out-of-range byte counts mean a full word; bytes past the count are zeroed.
  always_comb begin
    bytes_eff   = (in_bytes == 3'd0 || in_bytes > 3'd4) ? 3'd4 : in_bytes;
    word_masked = in_data;
    if (in_last) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) >= bytes_eff) begin
          word_masked[8*b +: 8] = 8'h00;
        end
      end
    end
  end

  assign full     = (cnt_q == CW'(DEPTH));
  assign in_ready = ~rst & (state_q == COLLECT) & ~full;
  assign accept   = in_valid & in_ready;
  assign blk_end  = in_last | (lane_q == 2'd3);
  assign wr_fire  = (state_q == WRITE);
  assign done_eff = blk_done & (cnt_q != '0);
  assign len_d    = 5'({lane_q, 2'b00}) + 5'(bytes_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      lane_q      <= '0;
      asm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      w_en_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_len_q  <= '0;
      last_vld_q  <= 1'b0;
      last_addr_q <= '0;
      last_len_q  <= '0;
    end else begin
      w_en_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (accept) begin
            asm_q[{lane_q, 5'd0} +: 32] <= word_masked;
            if (blk_end) begin
              state_q     <= WRITE;
              lane_q      <= '0;
              w_en_q      <= 1'b1;
              pend_last_q <= in_last;
              pend_len_q  <= len_d;
            end else begin
              lane_q <= lane_q + 2'd1;
            end
          end
        end
        WRITE: begin
          state_q  <= COLLECT;
          asm_q    <= '0;
          wr_ptr_q <= wr_ptr_q + A_WIDTH'(1);
        end
      endcase

      // Occupancy: a write and a retire in the same cycle cancel out.
      if (wr_fire && !done_eff) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!wr_fire && done_eff) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (done_eff) begin
        rd_ptr_q <= rd_ptr_q + A_WIDTH'(1);
      end

      // A newly written final block wins over retiring the previous one.
      if (wr_fire && pend_last_q) begin
        last_vld_q  <= 1'b1;
        last_addr_q <= wr_ptr_q;
        last_len_q  <= pend_len_q;
      end else if (done_eff && last_vld_q && (rd_ptr_q == last_addr_q)) begin
        last_vld_q <= 1'b0;
      end
    end
  end

  assign w_en      = w_en_q;
  assign w_addr    = wr_ptr_q;
  assign w_data    = asm_q;
  assign blk_cnt   = cnt_q;
  assign last_vld  = last_vld_q;
  assign last_addr = last_addr_q;
  assign last_len  = last_len_q;

endmodule

// File: doc/msg_ram_writer.md
MSG_RAM_WRITER -- requirements
Module: msg_ram_writer

Interface
REQ-001 Parameter D_WIDTH, default 128: RAM word width in bits.
REQ-002 Parameter A_WIDTH, default 3: RAM address width, giving 2**A_WIDTH = 8 slots.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 in_valid  input  1: in_data/in_last/in_bytes are valid this cycle.
REQ-006 in_ready  output  1: block accepts a word this cycle.
REQ-007 in_data  input  32: message word, little-endian (byte 0 in bits [7:0]).
REQ-008 in_last  input  1: this word is the final word of the message.
REQ-009 in_bytes  input  3: valid bytes in the final word, 1..4; ignored unless in_last=1.
REQ-010 w_en  output  1: RAM write strobe, one cycle per block.
REQ-011 w_addr  output  A_WIDTH: RAM write address.
REQ-012 w_data  output  D_WIDTH: packed 128-bit block.
REQ-013 blk_done  input  1: downstream has retired the oldest stored block (one-cycle pulse).
REQ-014 blk_cnt  output  A_WIDTH+1: number of occupied slots, 0..8.
REQ-015 last_vld  output  1: a final (in_last) block is stored and not yet retired.
REQ-016 last_addr  output  A_WIDTH: slot address holding the final block.
REQ-017 last_len  output  5: valid bytes in the final block, 1..16.

Function
REQ-018 The FSM SHALL have states COLLECT and WRITE; it SHALL reset into COLLECT.
REQ-019 in_ready SHALL be 1 iff state=COLLECT and blk_cnt<8; a word is accepted when in_valid and in_ready are both 1.
REQ-020 In COLLECT, a 2-bit lane counter (0..3) SHALL place each accepted word into bits [32*lane+31 : 32*lane] of the assembly register and then increment.
REQ-021 Accepting at lane 3, or accepting with in_last=1, SHALL move the FSM to WRITE and reset the lane counter to 0.
REQ-022 In WRITE, for exactly one cycle, the block SHALL drive w_en=1, w_addr=wr_ptr and w_data=assembly register, then return to COLLECT with the assembly register cleared.
REQ-023 Latency: a word accepted in cycle N that completes a block SHALL produce w_en=1 in cycle N+1; the earliest next acceptance SHALL be cycle N+2.
REQ-024 Partial final block: lanes above the last lane, and bytes of the last word beyond in_bytes, SHALL be zero in w_data.
REQ-025 wr_ptr SHALL increment modulo 8 on each write (7 -> 0); rd_ptr SHALL increment modulo 8 on each effective blk_done.
REQ-026 blk_cnt SHALL increment on a write, decrement on an effective blk_done, and stay unchanged when both occur in the same cycle.
REQ-027 blk_done with blk_cnt=0 SHALL be ignored: no change to pointers or count.
REQ-028 When blk_cnt=8, input SHALL stall (in_ready=0) and no write SHALL be issued; the write path SHALL never overwrite an unretired slot.
REQ-029 When the in_last block is written, last_vld SHALL be set to 1, last_addr to wr_ptr, and last_len to 4*lane_index + in_bytes.
REQ-030 last_vld SHALL clear when an effective blk_done occurs with rd_ptr=last_addr and last_vld=1; a simultaneous new final-block write SHALL take priority and set last_vld.
REQ-031 in_bytes values of 0 or above 4 with in_last=1 SHALL be treated as 4.

Reset
REQ-032 On rst=1, the block SHALL set state=COLLECT and clear the lane counter, wr_ptr, rd_ptr, blk_cnt and the assembly register; outputs SHALL be w_en=0, w_addr=0, w_data=0, last_vld=0, last_addr=0, last_len=0 and in_ready=0 while rst=1.
REQ-033 Reset asserted during WRITE SHALL suppress the pending write; the partial block SHALL be discarded.

Verification
REQ-034 Full block: words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in consecutive cycles -> w_en=1 one cycle after the 4th word, w_addr=0, w_data=0x0F0E0D0C_0B0A0908_07060504_03020100, blk_cnt=1.
REQ-035 Partial last: 2 words, the 2nd with in_last=1 and in_bytes=3, data 0xAABBCCDD -> upper 64 bits of w_data=0, word 1=0x00BBCCDD, last_vld=1, last_len=7.
REQ-036 Full/wrap: 8 blocks written with no blk_done -> blk_cnt=8 and in_ready=0; one blk_done -> blk_cnt=7; 9th block -> w_addr=0.
REQ-037 Simultaneous: write and blk_done in the same cycle at blk_cnt=3 -> blk_cnt stays 3; blk_done at blk_cnt=0 -> no change.
REQ-038 Reset: rst pulsed in the WRITE cycle -> no w_en, blk_cnt=0, next block written to w_addr=0.
